// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared encodings and FSM state type for the tic-tac-toe board controller
// Contents: cell codes, win-checker codes, game_state codes, controller FSM states,
// NUM_CELLS, and a helper mapping the player bit to its cell code.

package ttt_pkg;

  localparam int NUM_CELLS = 9;

  localparam logic [2:0] CELL_O     = 3'b000;
  localparam logic [2:0] CELL_X     = 3'b001;
  localparam logic [2:0] CELL_EMPTY = 3'b011;

  localparam logic [2:0] WIN_NONE = 3'd0;
  localparam logic [2:0] WIN_O    = 3'd1;
  localparam logic [2:0] WIN_X    = 3'd2;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    O_WIN = 2'd1,
    X_WIN = 2'd2,
    DRAW  = 2'd3
  } game_state_e;

  typedef enum logic [2:0] {
    ST_PLAY     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_END_O    = 3'd2,
    ST_END_X    = 3'd3,
    ST_END_DRAW = 3'd4
  } ctrl_state_e;

  // Player bit 0 = O, 1 = X.
  function automatic logic [2:0] player_cell(input logic player);
    return player ? CELL_X : CELL_O;
  endfunction

endpackage

// File: rtl/tic_tac_toe_turn_timer.sv
// rtl/tic_tac_toe_turn_timer.sv - per-turn cycle counter with expiry flag
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   clear_i        - restart the turn count (has priority over counting)
//   count_en_i     - count this cycle (controller is waiting for a move)
//   expired_o      - this is the TIMEOUT_CYCLES-th counted cycle of the turn

module tic_tac_toe_turn_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of cycles already spent in this turn, so the
  // current cycle is the last allowed one when it equals TIMEOUT_CYCLES-1.
  assign expired_o = count_en_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/tic_tac_toe_board_ctrl.sv
// rtl/tic_tac_toe_board_ctrl.sv - board registers and turn FSM for tic-tac-toe
// Optional feature macro: TTT_MOVE_TIMEOUT_EN (per-turn forfeit after TIMEOUT_CYCLES).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   new_game              - synchronous board clear, beats move_valid
//   move_valid/move_pos   - offered move (cell 0..8, row-major); move_ready high in PLAY
//   move_accept/reject    - registered one-cycle result pulses
//   win_condition         - external win checker result, sampled in CHECK
//   top_left..bottom_right- cell registers (O=000, X=001, empty=011)
//   current_player, move_count, game_state - game status

module tic_tac_toe_board_ctrl
  import ttt_pkg::*;
#(
  parameter bit FIRST_PLAYER   = 1'b0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic       move_accept,
  output logic       move_reject,
  input  logic [2:0] win_condition,
  output logic [2:0] top_left,
  output logic [2:0] top_middle,
  output logic [2:0] top_right,
  output logic [2:0] middle_left,
  output logic [2:0] middle_middle,
  output logic [2:0] middle_right,
  output logic [2:0] bottom_left,
  output logic [2:0] bottom_middle,
  output logic [2:0] bottom_right,
  output logic       current_player,
  output logic [3:0] move_count,
  output logic [1:0] game_state
);

  ctrl_state_e                    state_q, state_d;
  logic [NUM_CELLS-1:0][2:0]      board_q, board_d;
  logic [3:0]                     count_q, count_d;
  logic                           player_q, player_d;
  logic                           accept_q, accept_d;
  logic                           reject_q, reject_d;
  logic                           target_empty;
  logic                           timeout_expired;

`ifdef TTT_MOVE_TIMEOUT_EN
  // Counter restarts whenever we are outside PLAY (covers entry to PLAY),
  // on a rejected move, and on a board clear.
  tic_tac_toe_turn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_turn_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (new_game || (state_q != ST_PLAY) || reject_d),
    .count_en_i(state_q == ST_PLAY),
    .expired_o (timeout_expired)
  );
`else
  logic timeout_param_unused;
  assign timeout_param_unused = (TIMEOUT_CYCLES > 0);
  assign timeout_expired      = 1'b0;
`endif

  // Selecting by comparison keeps out-of-range positions (9..15) reading as
  // "not empty" without indexing past the board.
  always_comb begin
    target_empty = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (move_pos == 4'(i)) begin
        target_empty = (board_q[i] == CELL_EMPTY);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    count_d  = count_q;
    player_d = player_q;
    accept_d = 1'b0;
    reject_d = 1'b0;

    case (state_q)
      ST_PLAY: begin
        if (move_valid) begin
          // A move in the expiry cycle still wins over the timeout.
          if (target_empty) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
              if (move_pos == 4'(i)) begin
                board_d[i] = player_cell(player_q);
              end
            end
            count_d  = count_q + 4'd1;
            accept_d = 1'b1;
            state_d  = ST_CHECK;
          end else begin
            reject_d = 1'b1;
          end
        end else if (timeout_expired) begin
          // Player to move forfeits.
          state_d = player_q ? ST_END_O : ST_END_X;
        end
      end

      ST_CHECK: begin
        // Win beats draw so a ninth-move win is reported as a win.
        if (win_condition == WIN_O) begin
          state_d = ST_END_O;
        end else if (win_condition == WIN_X) begin
          state_d = ST_END_X;
        end else if (count_q == 4'(NUM_CELLS)) begin
          state_d = ST_END_DRAW;
        end else begin
          player_d = ~player_q;
          state_d  = ST_PLAY;
        end
      end

      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      state_q  <= ST_PLAY;
      board_q  <= {NUM_CELLS{CELL_EMPTY}};
      count_q  <= 4'd0;
      player_q <= FIRST_PLAYER;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      count_q  <= count_d;
      player_q <= player_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_END_O:    game_state = O_WIN;
      ST_END_X:    game_state = X_WIN;
      ST_END_DRAW: game_state = DRAW;
      default:     game_state = PLAY;
    endcase
  end

  assign move_ready     = (state_q == ST_PLAY);
  assign move_accept    = accept_q;
  assign move_reject    = reject_q;
  assign current_player = player_q;
  assign move_count     = count_q;

  assign top_left      = board_q[0];
  assign top_middle    = board_q[1];
  assign top_right     = board_q[2];
  assign middle_left   = board_q[3];
  assign middle_middle = board_q[4];
  assign middle_right  = board_q[5];
  assign bottom_left   = board_q[6];
  assign bottom_middle = board_q[7];
  assign bottom_right  = board_q[8];

endmodule

// File: tb/tb_tic_tac_toe_board_ctrl.sv
// tb/tb_tic_tac_toe_board_ctrl.sv - self-checking bench for tic_tac_toe_board_ctrl

module tb_tic_tac_toe_board_ctrl;

  localparam logic [2:0] CO = 3'b000;
  localparam logic [2:0] CX = 3'b001;
  localparam logic [2:0] CE = 3'b011;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;
  logic       move_accept;
  logic       move_reject;
  logic [2:0] win_condition;
  logic [2:0] top_left, top_middle, top_right;
  logic [2:0] middle_left, middle_middle, middle_right;
  logic [2:0] bottom_left, bottom_middle, bottom_right;
  logic       current_player;
  logic [3:0] move_count;
  logic [1:0] game_state;

  logic [8:0][2:0] board;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tic_tac_toe_board_ctrl #(
    .FIRST_PLAYER  (1'b0),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .new_game      (new_game),
    .move_valid    (move_valid),
    .move_pos      (move_pos),
    .move_ready    (move_ready),
    .move_accept   (move_accept),
    .move_reject   (move_reject),
    .win_condition (win_condition),
    .top_left      (top_left),
    .top_middle    (top_middle),
    .top_right     (top_right),
    .middle_left   (middle_left),
    .middle_middle (middle_middle),
    .middle_right  (middle_right),
    .bottom_left   (bottom_left),
    .bottom_middle (bottom_middle),
    .bottom_right  (bottom_right),
    .current_player(current_player),
    .move_count    (move_count),
    .game_state    (game_state)
  );

  assign board = {bottom_right, bottom_middle, bottom_left,
                  middle_right, middle_middle, middle_left,
                  top_right, top_middle, top_left};

  // Reference win checker driving the DUT's win_condition input.
  function automatic logic [2:0] line_win(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] c);
    if (a == CO && b == CO && c == CO) return 3'd1;
    if (a == CX && b == CX && c == CX) return 3'd2;
    return 3'd0;
  endfunction

  function automatic logic [2:0] win_of(input logic [8:0][2:0] b);
    logic [2:0] r;
    r = 3'd0;
    if (r == 3'd0) r = line_win(b[0], b[1], b[2]);
    if (r == 3'd0) r = line_win(b[3], b[4], b[5]);
    if (r == 3'd0) r = line_win(b[6], b[7], b[8]);
    if (r == 3'd0) r = line_win(b[0], b[3], b[6]);
    if (r == 3'd0) r = line_win(b[1], b[4], b[7]);
    if (r == 3'd0) r = line_win(b[2], b[5], b[8]);
    if (r == 3'd0) r = line_win(b[0], b[4], b[8]);
    if (r == 3'd0) r = line_win(b[2], b[4], b[6]);
    return r;
  endfunction

  assign win_condition = win_of(board);

  typedef struct {
    logic       ng;
    logic       v;
    logic [3:0] pos;
    logic       acc;
    logic       rej;
    logic [3:0] cnt;
    logic       ply;
    logic [1:0] gs;
    logic       rdy;
    int         cidx;
    logic [2:0] cval;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ng, input logic v, input logic [3:0] pos,
                     input logic acc, input logic rej, input logic [3:0] cnt,
                     input logic ply, input logic [1:0] gs, input logic rdy,
                     input int cidx, input logic [2:0] cval);
    vec_t e;
    e.ng = ng; e.v = v; e.pos = pos; e.acc = acc; e.rej = rej; e.cnt = cnt;
    e.ply = ply; e.gs = gs; e.rdy = rdy; e.cidx = cidx; e.cval = cval;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int draw_seq[9];
    logic       pl;
    draw_seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    // O wins along the top row: O0 X3 O1 X4 O2
    add(0,1,4'd0, 1,0,4'd1,0,2'd0,0, 0,CO);
    add(0,0,4'd0, 0,0,4'd1,1,2'd0,1, -1,CE);
    add(0,1,4'd3, 1,0,4'd2,1,2'd0,0, 3,CX);
    add(0,0,4'd0, 0,0,4'd2,0,2'd0,1, -1,CE);
    add(0,1,4'd1, 1,0,4'd3,0,2'd0,0, 1,CO);
    add(0,0,4'd0, 0,0,4'd3,1,2'd0,1, -1,CE);
    add(0,1,4'd4, 1,0,4'd4,1,2'd0,0, 4,CX);
    add(0,0,4'd0, 0,0,4'd4,0,2'd0,1, -1,CE);
    add(0,1,4'd2, 1,0,4'd5,0,2'd0,0, 2,CO);
    add(0,0,4'd0, 0,0,4'd5,0,2'd1,0, -1,CE);
    add(0,1,4'd5, 0,0,4'd5,0,2'd1,0, 5,CE);
    add(1,0,4'd0, 0,0,4'd0,0,2'd0,1, 0,CE);
    // occupied cell and out-of-range rejects
    add(0,1,4'd4, 1,0,4'd1,0,2'd0,0, 4,CO);
    add(0,0,4'd0, 0,0,4'd1,1,2'd0,1, -1,CE);
    add(0,1,4'd4, 0,1,4'd1,1,2'd0,1, 4,CO);
    add(0,1,4'd9, 0,1,4'd1,1,2'd0,1, 4,CO);
    add(0,1,4'd15,0,1,4'd1,1,2'd0,1, -1,CE);
    add(0,0,4'd0, 0,0,4'd1,1,2'd0,1, -1,CE);
    // new_game with a move in PLAY mid-game
    add(1,1,4'd0, 0,0,4'd0,0,2'd0,1, 0,CE);
    add(0,0,4'd0, 0,0,4'd0,0,2'd0,1, 4,CE);
    // new_game with a move while in CHECK
    add(0,1,4'd0, 1,0,4'd1,0,2'd0,0, 0,CO);
    add(1,1,4'd1, 0,0,4'd0,0,2'd0,1, 0,CE);
    add(0,0,4'd0, 0,0,4'd0,0,2'd0,1, 1,CE);
    // move offered during CHECK is ignored
    add(0,1,4'd0, 1,0,4'd1,0,2'd0,0, 0,CO);
    add(0,1,4'd1, 0,0,4'd1,1,2'd0,1, 1,CE);
    add(1,0,4'd0, 0,0,4'd0,0,2'd0,1, -1,CE);
    // draw game
    for (int k = 0; k < 9; k++) begin
      pl = k[0];
      add(0,1,4'(draw_seq[k]), 1,0,4'(k+1),pl,2'd0,0, draw_seq[k], pl ? CX : CO);
      if (k == 8) add(0,0,4'd0, 0,0,4'd9,pl,2'd3,0, -1,CE);
      else        add(0,0,4'd0, 0,0,4'(k+1),~pl,2'd0,1, -1,CE);
    end
    add(0,1,4'd0, 0,0,4'd9,0,2'd3,0, 0,CO);
    add(0,1,4'd9, 0,0,4'd9,0,2'd3,0, 8,CO);
    add(1,0,4'd0, 0,0,4'd0,0,2'd0,1, 8,CE);

    // Reset, with a move offered during it
    reset = 1'b1; new_game = 1'b0; move_valid = 1'b1; move_pos = 4'd0;
    tick();
    tick();
    for (int i = 0; i < 9; i++) chk($sformatf("reset.cell%0d", i), 32'(board[i]), 32'(CE));
    chk("reset.count", 32'(move_count), 32'd0);
    chk("reset.player", 32'(current_player), 32'd0);
    chk("reset.ready", 32'(move_ready), 32'd1);
    chk("reset.gs", 32'(game_state), 32'd0);
    chk("reset.acc", 32'(move_accept), 32'd0);
    reset = 1'b0; move_valid = 1'b0;
    tick();

    foreach (tbl[i]) begin
      new_game   = tbl[i].ng;
      move_valid = tbl[i].v;
      move_pos   = tbl[i].pos;
      tick();
      chk($sformatf("v%0d.acc", i), 32'(move_accept), 32'(tbl[i].acc));
      chk($sformatf("v%0d.rej", i), 32'(move_reject), 32'(tbl[i].rej));
      chk($sformatf("v%0d.cnt", i), 32'(move_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d.ply", i), 32'(current_player), 32'(tbl[i].ply));
      chk($sformatf("v%0d.gs", i), 32'(game_state), 32'(tbl[i].gs));
      chk($sformatf("v%0d.rdy", i), 32'(move_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d.excl", i), 32'(move_accept & move_reject), 32'd0);
      if (tbl[i].cidx >= 0)
        chk($sformatf("v%0d.cell%0d", i, tbl[i].cidx), 32'(board[tbl[i].cidx]), 32'(tbl[i].cval));
    end
    new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;

    // Synchronous reset while in CHECK with a move offered
    move_valid = 1'b1; move_pos = 4'd4;
    tick();
    chk("rst_mid.acc1", 32'(move_accept), 32'd1);
    reset = 1'b1; move_pos = 4'd0;
    tick();
    reset = 1'b0; move_valid = 1'b0;
    chk("rst_mid.cell4", 32'(middle_middle), 32'(CE));
    chk("rst_mid.cell0", 32'(top_left), 32'(CE));
    chk("rst_mid.acc", 32'(move_accept), 32'd0);
    chk("rst_mid.cnt", 32'(move_count), 32'd0);
    chk("rst_mid.ply", 32'(current_player), 32'd0);
    chk("rst_mid.rdy", 32'(move_ready), 32'd1);

`ifdef TTT_MOVE_TIMEOUT_EN
    // O idles for the full turn and forfeits to X
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    repeat (7) tick();
    chk("to.before_gs", 32'(game_state), 32'd0);
    chk("to.before_rdy", 32'(move_ready), 32'd1);
    tick();
    chk("to.gs", 32'(game_state), 32'd2);
    chk("to.rdy", 32'(move_ready), 32'd0);
    chk("to.acc", 32'(move_accept), 32'd0);
    chk("to.cnt", 32'(move_count), 32'd0);
    // A move in the expiry cycle wins over the timeout
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    repeat (7) tick();
    move_valid = 1'b1; move_pos = 4'd0;
    tick();
    move_valid = 1'b0;
    chk("to_mv.acc", 32'(move_accept), 32'd1);
    chk("to_mv.gs", 32'(game_state), 32'd0);
    chk("to_mv.cell0", 32'(top_left), 32'(CO));
    tick();
    chk("to_mv.gs2", 32'(game_state), 32'd0);
    chk("to_mv.ply", 32'(current_player), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
